// File: rtl/operand_loader_pkg.sv
// Shared types and helpers for the serial operand loader feeding the 4-bit sum adder.
package operand_loader_pkg;

    localparam int OPERAND_WIDTH = 4;
    localparam int COUNT_WIDTH   = 2;
    localparam logic [COUNT_WIDTH-1:0] LAST_BIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        PRESENT
    } loader_state_t;

    // After four shifts the first bit ends up in bit 0 (LSB-first) or bit 3 (MSB-first).
    function automatic logic [OPERAND_WIDTH-1:0] shift_in(
        input logic [OPERAND_WIDTH-1:0] value,
        input logic                     din,
        input logic                     msb_first
    );
        if (msb_first)
            return {value[OPERAND_WIDTH-2:0], din};
        else
            return {din, value[OPERAND_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/operand_loader_shift_reg4.sv
// Four-bit serial-in parallel-out register with synchronous clear, one instance per operand.
module shift_reg4
    import operand_loader_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     shift_en,
    input  logic                     din,
    output logic [OPERAND_WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset || clear)
            value <= '0;
        else if (shift_en)
            value <= shift_in(value, din, MSB_FIRST);
    end

endmodule

// File: rtl/operand_loader.sv
// Collects two serial 4-bit operands and holds the completed pair for the sum adder until consumed.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic serial_in,
    input  logic bit_valid,
    input  logic consume,
    output logic x0,
    output logic x1,
    output logic x2,
    output logic x3,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic operands_valid,
    output logic busy
);

    loader_state_t            state;
    logic [COUNT_WIDTH-1:0]   bit_count;
    logic [OPERAND_WIDTH-1:0] x_shift;
    logic [OPERAND_WIDTH-1:0] y_shift;
    logic [OPERAND_WIDTH-1:0] y_next;
    logic [OPERAND_WIDTH-1:0] x_hold;
    logic [OPERAND_WIDTH-1:0] y_hold;
    logic                     begin_load;
    logic                     shift_x;
    logic                     shift_y;

    // A new load starts from IDLE, or from PRESENT when the consumer acknowledges and restarts at once.
    assign begin_load = start && ((state == IDLE) || ((state == PRESENT) && consume));
    assign shift_x    = (state == LOAD_X) && bit_valid;
    assign shift_y    = (state == LOAD_Y) && bit_valid;

    // The Y register has not yet absorbed the final bit when the pair is captured.
    assign y_next = shift_in(y_shift, serial_in, MSB_FIRST);

    shift_reg4 #(
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_x (
        .clk      (clk),
        .reset    (reset),
        .clear    (begin_load),
        .shift_en (shift_x),
        .din      (serial_in),
        .value    (x_shift)
    );

    shift_reg4 #(
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_y (
        .clk      (clk),
        .reset    (reset),
        .clear    (begin_load),
        .shift_en (shift_y),
        .din      (serial_in),
        .value    (y_shift)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bit_count      <= '0;
            x_hold         <= '0;
            y_hold         <= '0;
            operands_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD_X;
                        bit_count <= '0;
                        busy      <= 1'b1;
                    end
                end
                LOAD_X: begin
                    if (bit_valid) begin
                        bit_count <= bit_count + 2'd1;
                        if (bit_count == LAST_BIT)
                            state <= LOAD_Y;
                    end
                end
                LOAD_Y: begin
                    if (bit_valid) begin
                        bit_count <= bit_count + 2'd1;
                        if (bit_count == LAST_BIT) begin
                            state          <= PRESENT;
                            busy           <= 1'b0;
                            x_hold         <= x_shift;
                            y_hold         <= y_next;
                            operands_valid <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (consume) begin
                        operands_valid <= 1'b0;
                        if (start) begin
                            state     <= LOAD_X;
                            bit_count <= '0;
                            busy      <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {x3, x2, x1, x0} = x_hold;
    assign {y3, y2, y1, y0} = y_hold;

endmodule

// File: doc/operand_loader.md
# operand_loader

Serial front end for the 4-bit `sum` adder. Collects two 4-bit operands one bit per accepted strobe and presents them as the adder's eight single-bit inputs. Holds each completed pair stable until the consumer acknowledges it. Sits directly upstream of `sum`: its `x0..x3` and `y0..y3` outputs wire straight to the adder's operand ports.

## Interface
- `MSB_FIRST`, default 0: bit order of the serial stream. 0 means the first accepted bit of each operand lands in bit 0 (`x0`/`y0`). 1 means it lands in bit 3.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin collecting a new operand pair.
- `serial_in` input 1: data bit, sampled when `bit_valid` is 1.
- `bit_valid` input 1: strobe qualifying `serial_in`.
- `consume` input 1: downstream acknowledge of the presented pair.
- `x0`, `x1`, `x2`, `x3` output 1 each: operand X, `x0` = LSB.
- `y0`, `y1`, `y2`, `y3` output 1 each: operand Y, `y0` = LSB.
- `operands_valid` output 1: presented pair is complete and new.
- `busy` output 1: high in LOAD_X and LOAD_Y.

## Operation
- States:
  - IDLE: waiting for `start`.
  - LOAD_X: collecting X.
  - LOAD_Y: collecting Y.
  - PRESENT: pair complete, waiting for `consume`.
- Reset:
  - State goes to IDLE.
  - All x/y outputs, `operands_valid` and `busy` go to 0.
  - Bit counter and both shift registers clear to 0.
- IDLE:
  - `start`=1 → LOAD_X, with the counter and shift registers cleared.
  - `bit_valid` is ignored.
- LOAD_X:
  - Each `bit_valid`=1 edge shifts `serial_in` into the X shift register and increments the 2-bit counter.
  - The 4th accepted bit moves to LOAD_Y and the counter wraps to 0.
  - `bit_valid`=0 cycles are stalls; there is no timeout.
- LOAD_Y: same as LOAD_X for Y. The 4th accepted bit moves to PRESENT.
- Output update on that 4th Y bit edge:
  - x/y outputs copy the shift registers, with the Y register including the bit being sampled.
  - `operands_valid` rises on the same edge.
- Output hold rule: outputs change only on entry to PRESENT or on reset. During loading they keep the previously presented pair, so the adder never sees a partial operand.
- PRESENT:
  - `consume`=1 → IDLE, and `operands_valid` clears.
  - `consume`=1 together with `start`=1 → LOAD_X directly, with `operands_valid` cleared and the shift registers cleared.
  - `bit_valid` is ignored.
- `start` outside IDLE/PRESENT is ignored. It does not restart a load in progress.
- `consume` outside PRESENT is ignored.
- `reset` mid-load aborts the load: IDLE, outputs zeroed, no partial pair presented.

## Timing
- Latency: `operands_valid` is high in the cycle after the edge sampling the 8th accepted bit. Minimum is 9 edges from the `start` edge (1 start + 8 bits).
- Back-to-back throughput with `consume`+`start` overlap: one pair per 9 cycles.
- `busy` is registered. It is high from the edge after `start` until the edge that enters PRESENT.
- `operands_valid` and x/y outputs are registered, with no combinational path from any input.
- Adder results are valid combinationally while `operands_valid`=1. The consumer samples them before asserting `consume`.

## Structure
- Package `operand_loader_pkg`:
  - `OPERAND_WIDTH` = 4.
  - State enum `loader_state_t` {IDLE, LOAD_X, LOAD_Y, PRESENT}.
- Sub-module `shift_reg4`, instantiated twice (X, Y):
  - Inputs: clk, reset, clear, shift_en, din.
  - Parameter `MSB_FIRST`.
  - Output: 4-bit parallel value.
- Top level holds the FSM, the counter, and the output holding registers.

## Test plan
- Reset and idle:
  - Reset, then 3 idle cycles → all outputs 0, state IDLE.
  - `bit_valid` pulses in IDLE → no change.
- Basic load, LSB-first:
  - `start`, then bits 1,0,1,0 for X and 1,1,0,0 for Y.
  - Required: `x0..x3`=1,0,1,0; `y0..y3`=1,1,0,0; adder `o0..o3`=0,0,0,1, carry 0.
  - `operands_valid`=1 exactly 9 cycles after `start`.
- Stalls and hold:
  - Insert `bit_valid`=0 gaps between bits, after a prior pair X=1111, Y=0001 was presented.
  - Required: outputs stay 1111/0001 throughout loading.
  - The new pair appears only on the 8th bit edge.
  - With that prior pair presented, carry=1 and `o`=0000.
- Ignore rules:
  - `start` during LOAD_Y → ignored, load completes normally.
  - `consume` during LOAD_X → ignored.
- Overlap:
  - In PRESENT, `consume`+`start` in the same cycle → next cycle LOAD_X, `operands_valid`=0, `busy`=1.
  - Second pair X=0011, Y=0110 → `o`=1001, carry 0.
- Reset mid-load and `MSB_FIRST`=1:
  - Reset after 5 bits → IDLE, outputs 0, `operands_valid` never asserted.
  - With `MSB_FIRST`=1, bits 1,0,0,0 → `x3`=1, others 0.
